dag_burst_arbiter: RTL and testbench
====================================

# dag_burst_arbiter

Sequencer and arbiter in front of the data address generator (DAG). It shares the DAG's single access slot between three requesters: the program sequencer's single-cycle accesses, a DM block-transfer channel (ch0) and a PM block-transfer channel (ch1). It drives the DAG control inputs (enable, DM/PM select, modify mode, I/M indices) so that each accepted burst performs N post-modify accesses. Channel arbitration is round-robin, and the program sequencer always has priority.

## Interface
- CNT_W, default 8: burst length counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ps_req  in  1  program-sequencer DAG access this cycle.
- ps_dgsclt, ps_mdfy  in  1 each  program-sequencer select and modify fields.
- ps_iadd, ps_madd  in  3 each  program-sequencer I and M indices.
- ps_gnt  out  1  equals ps_req; the program sequencer is never stalled.
- ch0_req, ch1_req  in  1 each  burst request, level; ch0 is DM, ch1 is PM.
- ch0_iadd, ch0_madd, ch1_iadd, ch1_madd  in  3 each  burst I and M indices.
- ch0_cnt, ch1_cnt  in  CNT_W each  number of accesses in the burst.
- ch0_ack, ch1_ack  out  1 each  burst accepted this cycle.
- ch0_done, ch1_done  out  1 each  one-cycle pulse when the burst completes.
- abort  in  1  cancel the active burst.
- mem_rdy  in  1  memory accepts an address this cycle.
- dg_en, dg_dgsclt, dg_mdfy  out  1 each  DAG controls.
- dg_iadd, dg_madd  out  3 each  DAG indices.
- busy  out  1  a burst is active (state RUN).

## Operation
- States are IDLE and RUN. Registers:
  - act_ch: channel being served.
  - i_lat, m_lat: latched indices.
  - rem (CNT_W bits): accesses remaining.
  - rr_last: last channel served.
  - done_q[1:0]: registered done pulses.
- Arbitration happens only in IDLE and is combinational that cycle:
  - Only one channel requesting: that channel wins.
  - Both requesting: the channel other than rr_last wins.
- On acceptance:
  - chX_ack is high that cycle.
  - Indices and cnt are latched, and rr_last is set to X.
  - If cnt is nonzero, the next state is RUN.
  - If cnt is 0, chX_done pulses in the same cycle as ack and the block stays in IDLE.
- The requester must drop req in the cycle after ack; a req still high is treated as a new burst.
- A beat occurs when the state is RUN, ps_req is 0 and mem_rdy is 1. During a beat:
  - dg_en=1, dg_mdfy=0 (post-modify: the DAG outputs I, then I+=M).
  - dg_dgsclt=act_ch, dg_iadd=i_lat, dg_madd=m_lat.
  - rem decrements by 1.
- On the beat with rem==1, the state returns to IDLE and done_q[act_ch] is set. chX_done is high for the next cycle only.
- Output priority for the dg_* signals:
  - ps_req=1, in any state: dg_en=1, and the other dg_* signals pass the ps_* fields through. There is no beat and rem holds.
  - Otherwise, in a beat: burst values as above.
  - Otherwise: all dg_* outputs are 0.
- Stall: with mem_rdy=0 and ps_req=0 in RUN, dg_en=0 and no state changes.
- abort in RUN:
  - Next state is IDLE and rem is cleared.
  - No done pulse; rr_last is unchanged.
  - If abort coincides with the final beat, the beat is still driven and abort wins (no done).
- abort in IDLE has no effect.
- In the IDLE cycle where done pulses, a new request may be accepted (back-to-back bursts).

## Timing
- Reset is asynchronous:
  - State IDLE, rem=0, rr_last=1 (ch0 wins the first tie), done_q=0.
  - busy=0 and done=0.
  - ack and dg_* outputs are 0 unless ps_req or chX_req is high; with rst_n low, all acks and chX_done are forced to 0.
- Reset mid-burst abandons the burst immediately with no done pulse.
- The ps_req→dg_* path is combinational, and so is the mem_rdy→dg_en path.
- Latency, with acceptance in cycle 0 and mem_rdy=1, ps_req=0 throughout:
  - Beats in cycles 1..N.
  - busy high in cycles 1..N.
  - chX_done in cycle N+1.
- Each cycle of ps_req or mem_rdy low inside a burst delays done by 1.
- Throughput is one access per cycle. The next burst's first beat comes 2 cycles after the previous last beat (done/accept cycle, then beat).

## Test plan
- Reset, then ch0_req with iadd=2, madd=5, cnt=3.
  - Required: ch0_ack in cycle 0.
  - Cycles 1–3: dg_en=1, dg_dgsclt=0, dg_iadd=2, dg_madd=5, dg_mdfy=0.
  - ch0_done in cycle 4; busy high in cycles 1–3.
- ch0 and ch1 both request after reset (cnt=2 each); ch1_req held high until its ack.
  - Required: ch0 granted first.
  - ch1_ack in the same cycle as ch0_done.
  - ch1 beats with dg_dgsclt=1.
- Burst with cnt=3; mem_rdy low in cycles 2–3.
  - Required: dg_en=0 in those cycles.
  - Exactly 3 beats total; done moves from cycle 4 to cycle 6.
- ps_req=1 in cycle 2 of a cnt=3 burst, with ps_iadd=7, ps_madd=1, ps_mdfy=1, ps_dgsclt=1.
  - Required in that cycle: ps_gnt=1 and dg_* equal the ps fields.
  - rem holds; done moves to cycle 5.
- Zero-length and abort cases:
  - ch1_req with cnt=0 → ch1_ack and ch1_done in the same cycle, no dg_en, busy stays 0.
  - abort during a cnt=5 burst in cycle 3 → busy=0 from cycle 4, no done.
- Reset mid-burst:
  - rst_n pulsed low in cycle 2 of a cnt=4 burst → busy=0 and dg_en=0 immediately.
  - No done afterwards; the next tie is granted to ch0.

Source files
------------

// File: rtl/dag_burst_arbiter_if.sv
// Handshake bundle between the DAG burst arbiter and its requesters:
// program sequencer, two block-transfer channels, memory ready and DAG controls.
interface dag_burst_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             ps_req;
    logic             ps_dgsclt;
    logic             ps_mdfy;
    logic [2:0]       ps_iadd;
    logic [2:0]       ps_madd;
    logic             ps_gnt;

    logic             ch0_req;
    logic             ch1_req;
    logic [2:0]       ch0_iadd;
    logic [2:0]       ch0_madd;
    logic [2:0]       ch1_iadd;
    logic [2:0]       ch1_madd;
    logic [CNT_W-1:0] ch0_cnt;
    logic [CNT_W-1:0] ch1_cnt;
    logic             ch0_ack;
    logic             ch1_ack;
    logic             ch0_done;
    logic             ch1_done;

    logic             abort;
    logic             mem_rdy;

    logic             dg_en;
    logic             dg_dgsclt;
    logic             dg_mdfy;
    logic [2:0]       dg_iadd;
    logic [2:0]       dg_madd;
    logic             busy;

    modport master (
        output ps_req, ps_dgsclt, ps_mdfy, ps_iadd, ps_madd,
        output ch0_req, ch1_req, ch0_iadd, ch0_madd, ch1_iadd, ch1_madd,
        output ch0_cnt, ch1_cnt, abort, mem_rdy,
        input  ps_gnt, ch0_ack, ch1_ack, ch0_done, ch1_done,
        input  dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd, busy
    );

    modport slave (
        input  ps_req, ps_dgsclt, ps_mdfy, ps_iadd, ps_madd,
        input  ch0_req, ch1_req, ch0_iadd, ch0_madd, ch1_iadd, ch1_madd,
        input  ch0_cnt, ch1_cnt, abort, mem_rdy,
        output ps_gnt, ch0_ack, ch1_ack, ch0_done, ch1_done,
        output dg_en, dg_dgsclt, dg_mdfy, dg_iadd, dg_madd, busy
    );
endinterface

// File: rtl/dag_burst_arbiter.sv
// Shares the single DAG access slot between the program sequencer (always first)
// and two round-robin block-transfer channels, each burst doing N post-modify beats.
module dag_burst_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dag_burst_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state;
    logic             r_act_ch;
    logic [2:0]       r_i_lat;
    logic [2:0]       r_m_lat;
    logic [CNT_W-1:0] r_rem;
    logic             r_rr_last;
    logic [1:0]       r_done_q;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_beat;
    logic [CNT_W-1:0] w_acc_cnt;
    logic [2:0]       w_acc_i;
    logic [2:0]       w_acc_m;

    // On a tie the channel that was not served last wins.
    assign w_idle    = (r_state == IDLE);
    assign w_grant0  = w_idle & bus.ch0_req & (~bus.ch1_req | r_rr_last);
    assign w_grant1  = w_idle & bus.ch1_req & (~bus.ch0_req | ~r_rr_last);
    assign w_accept  = w_grant0 | w_grant1;
    assign w_acc_cnt = w_grant1 ? bus.ch1_cnt  : bus.ch0_cnt;
    assign w_acc_i   = w_grant1 ? bus.ch1_iadd : bus.ch0_iadd;
    assign w_acc_m   = w_grant1 ? bus.ch1_madd : bus.ch0_madd;
    assign w_beat    = (r_state == RUN) & ~bus.ps_req & bus.mem_rdy;

    assign bus.ps_gnt   = bus.ps_req;
    assign bus.busy     = (r_state == RUN);
    assign bus.ch0_ack  = rst_n & w_grant0;
    assign bus.ch1_ack  = rst_n & w_grant1;
    assign bus.ch0_done = rst_n & (r_done_q[0] | (w_grant0 & (bus.ch0_cnt == '0)));
    assign bus.ch1_done = rst_n & (r_done_q[1] | (w_grant1 & (bus.ch1_cnt == '0)));

    always_comb begin
        bus.dg_en     = 1'b0;
        bus.dg_dgsclt = 1'b0;
        bus.dg_mdfy   = 1'b0;
        bus.dg_iadd   = 3'd0;
        bus.dg_madd   = 3'd0;
        if (bus.ps_req) begin
            bus.dg_en     = 1'b1;
            bus.dg_dgsclt = bus.ps_dgsclt;
            bus.dg_mdfy   = bus.ps_mdfy;
            bus.dg_iadd   = bus.ps_iadd;
            bus.dg_madd   = bus.ps_madd;
        end else if (w_beat) begin
            bus.dg_en     = 1'b1;
            bus.dg_dgsclt = r_act_ch;
            bus.dg_iadd   = r_i_lat;
            bus.dg_madd   = r_m_lat;
        end
    end

    // Abort outranks the final beat, so an aborted burst never reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_act_ch  <= 1'b0;
            r_i_lat   <= 3'd0;
            r_m_lat   <= 3'd0;
            r_rem     <= '0;
            r_rr_last <= 1'b1;
            r_done_q  <= 2'b00;
        end else begin
            r_done_q <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_act_ch  <= w_grant1;
                        r_rr_last <= w_grant1;
                        r_i_lat   <= w_acc_i;
                        r_m_lat   <= w_acc_m;
                        r_rem     <= w_acc_cnt;
                        if (w_acc_cnt != '0) begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_rem   <= '0;
                    end else if (w_beat) begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            r_state            <= IDLE;
                            r_done_q[r_act_ch] <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dag_burst_arbiter.sv
// Cycle-by-cycle vector table for dag_burst_arbiter; expected outputs are queued
// when a cycle is driven and compared mid-cycle against the DUT.
module tb_dag_burst_arbiter;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [1:0] ack;
        logic [1:0] done;
        logic       en;
        logic       sel;
        logic       mdfy;
        logic [2:0] i;
        logic [2:0] m;
        logic       busy;
        logic       gnt;
    } out_t;

    typedef struct {
        string      name;
        logic       psReq;
        logic       c0;
        logic       c1;
        logic [7:0] cnt0;
        logic [7:0] cnt1;
        logic       rdy;
        logic       abt;
        out_t       exp;
    } vec_t;

    logic  clk;
    logic  rst_n;
    int    nVectors;
    int    nMiscompares;
    out_t  expQ[$];
    string nameQ[$];
    vec_t  vecs[$];

    dag_burst_arbiter_if #(.CNT_W(CNT_W)) bus();

    dag_burst_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected mdfy and gnt follow ps_req because the bench always drives ps_mdfy=1.
    function automatic vec_t mk(string name, logic psReq, logic c0, logic c1,
                                logic [7:0] cnt0, logic [7:0] cnt1, logic rdy, logic abt,
                                logic [1:0] ack, logic [1:0] done, logic en, logic sel,
                                logic [2:0] i, logic [2:0] m, logic busy);
        vec_t v;
        v.name  = name;
        v.psReq = psReq;
        v.c0    = c0;
        v.c1    = c1;
        v.cnt0  = cnt0;
        v.cnt1  = cnt1;
        v.rdy   = rdy;
        v.abt   = abt;
        v.exp   = '{ack: ack, done: done, en: en, sel: sel, mdfy: psReq,
                    i: i, m: m, busy: busy, gnt: psReq};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.ps_req    = v.psReq;
        bus.ps_dgsclt = 1'b1;
        bus.ps_mdfy   = 1'b1;
        bus.ps_iadd   = 3'd7;
        bus.ps_madd   = 3'd1;
        bus.ch0_req   = v.c0;
        bus.ch1_req   = v.c1;
        bus.ch0_iadd  = v.c0 ? 3'd2 : 3'd0;
        bus.ch0_madd  = v.c0 ? 3'd5 : 3'd0;
        bus.ch1_iadd  = v.c1 ? 3'd4 : 3'd0;
        bus.ch1_madd  = v.c1 ? 3'd3 : 3'd0;
        bus.ch0_cnt   = v.cnt0;
        bus.ch1_cnt   = v.cnt1;
        bus.mem_rdy   = v.rdy;
        bus.abort     = v.abt;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
    endtask

    task automatic checkOutput();
        out_t  act;
        out_t  exp;
        string name;
        act = '{ack: {bus.ch1_ack, bus.ch0_ack}, done: {bus.ch1_done, bus.ch0_done},
                en: bus.dg_en, sel: bus.dg_dgsclt, mdfy: bus.dg_mdfy,
                i: bus.dg_iadd, m: bus.dg_madd, busy: bus.busy, gnt: bus.ps_gnt};
        nVectors++;
        if (expQ.size() == 0) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard_empty: actual=%h required=entry", act);
            return;
        end
        exp  = expQ.pop_front();
        name = nameQ.pop_front();
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: actual ack=%b done=%b en=%b sel=%b mdfy=%b i=%0d m=%0d busy=%b gnt=%b required ack=%b done=%b en=%b sel=%b mdfy=%b i=%0d m=%0d busy=%b gnt=%b",
                     name, act.ack, act.done, act.en, act.sel, act.mdfy, act.i, act.m, act.busy, act.gnt,
                     exp.ack, exp.done, exp.en, exp.sel, exp.mdfy, exp.i, exp.m, exp.busy, exp.gnt);
        end
    endtask

    task automatic runCycle(input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput();
    endtask

    // Burst is abandoned by a reset pulse; rr_last must return to favour ch0.
    task automatic resetMidBurst();
        runCycle(mk("rst_acc",      0, 1, 0, 4, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        runCycle(mk("rst_beat1",    0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        @(posedge clk);
        #1;
        applyStimulus(mk("rst_low", 0, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput();
        bus.ch0_req = 1'b0;
        #1;
        rst_n = 1'b1;
        runCycle(mk("rst_after1",   0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        runCycle(mk("rst_after2",   0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        runCycle(mk("rst_tie",      0, 1, 1, 1, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        runCycle(mk("rst_tie_b0",   0, 0, 1, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        runCycle(mk("rst_tie_acc1", 0, 0, 1, 0, 1, 1, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0));
        runCycle(mk("rst_tie_b1",   0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        runCycle(mk("rst_tie_done", 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0));
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;

        // Tie right after reset: ch0 first, ch1 held until its ack.
        vecs.push_back(mk("tie_acc0",       0, 1, 1, 2, 2, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie_b0_1",       0, 0, 1, 0, 2, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("tie_b0_2",       0, 0, 1, 0, 2, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("tie_done0_acc1", 0, 0, 1, 0, 2, 1, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie_b1_1",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("tie_b1_2",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("tie_done1",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0));
        // Plain ch0 burst of 3.
        vecs.push_back(mk("c0_acc",         0, 1, 0, 3, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("c0_beat1",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("c0_beat2",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("c0_beat3",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("c0_done",        0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0));
        // mem_rdy low in cycles 2-3 pushes done to cycle 6.
        vecs.push_back(mk("stall_acc",      0, 0, 1, 0, 3, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("stall_beat1",    0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("stall_c2",       0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
        vecs.push_back(mk("stall_c3",       0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1));
        vecs.push_back(mk("stall_beat2",    0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("stall_beat3",    0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("stall_done",     0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0));
        // Program sequencer steals cycle 2.
        vecs.push_back(mk("ps_acc",         0, 1, 0, 3, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ps_beat1",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("ps_steal",       1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 7, 1, 1));
        vecs.push_back(mk("ps_beat2",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("ps_beat3",       0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("ps_done",        0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0));
        // Zero-length burst: ack and done together, never busy.
        vecs.push_back(mk("zero_len",       0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk("zero_after",     0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        // Abort in cycle 3 of a 5-beat burst.
        vecs.push_back(mk("abt_acc",        0, 1, 0, 5, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("abt_beat1",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("abt_beat2",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("abt_beat3",      0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("abt_idle1",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("abt_idle2",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        // Abort on the final beat: beat shown, no done.
        vecs.push_back(mk("abtl_acc",       0, 0, 1, 0, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("abtl_beat",      0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 4, 3, 1));
        vecs.push_back(mk("abtl_nodone",    0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        // Abort while idle does not block acceptance.
        vecs.push_back(mk("abti_acc",       0, 1, 0, 1, 0, 1, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk("abti_beat",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 2, 5, 1));
        vecs.push_back(mk("abti_done",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0));
        // ps passthrough while idle, then a zero-length tie (ch0 served last).
        vecs.push_back(mk("ps_idle",        1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 7, 1, 0));
        vecs.push_back(mk("tie0_ch1",       0, 1, 1, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie0_ch0",       0, 1, 0, 0, 0, 1, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk("tie0_idle",      0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

        rst_n = 1'b0;
        #1;
        applyStimulus(mk("reset_hold", 0, 1, 1, 3, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput();
        bus.ch0_req = 1'b0;
        bus.ch1_req = 1'b0;
        #1;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            runCycle(vecs[k]);
        end

        resetMidBurst();

        if (expQ.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard_leftover: actual=%0d required=0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
